parking_gate_ctrl: RTL and testbench

//  Barrier controller for one car park's entry and exit lanes. Drives the two barrier motors.

---
 rtl/parking_pkg.sv | 25 ++
 rtl/gate_lane_fsm.sv | 99 +++++++++
 rtl/parking_gate_ctrl.sv | 121 ++++++++++++
 tb/tb_parking_gate_ctrl.sv | 319 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/parking_pkg.sv
// Shared types and constants for the car park barrier controller.
// Contents:
//   gate_state_t     lane states IDLE / OPEN / PASSED / CLOSE
//   PASS_TIMEOUT_DEF default cycles a raised barrier waits for the pass sensor
//   CLOSE_CYCLES_DEF default cycles a lowered barrier is held before re-arming
//   MAX_SPACES       capacity of the car park, shared with the space counter
//   max_int          helper used to size lane timers
package parking_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    OPEN   = 2'd1,
    PASSED = 2'd2,
    CLOSE  = 2'd3
  } gate_state_t;

  localparam int PASS_TIMEOUT_DEF = 50_000_000;
  localparam int CLOSE_CYCLES_DEF = 25_000_000;
  localparam int MAX_SPACES       = 20;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/gate_lane_fsm.sv
// One barrier lane: state machine, shared up-counting timer and event strobe.
// Ports:
//   clk, reset  system clock, synchronous active-high reset
//   approach    car waiting at the barrier (level)
//   pass        car beyond the barrier (level)
//   allow       admission permitted; sampled only on the IDLE->OPEN decision
//   gate_up     registered barrier drive, 1 = raised
//   idle        lane is in IDLE
//   fire        car passed this cycle; the top registers it into the lane event
//   timeout     OPEN gave up waiting for the pass sensor this cycle
//
// state  | meaning
// IDLE   | barrier down, waiting for an admitted approach
// OPEN   | barrier up, waiting for the car to pass (timeout guarded)
// PASSED | barrier up, car still on the pass sensor
// CLOSE  | barrier down, held for CLOSE_CYCLES before re-arming
module gate_lane_fsm import parking_pkg::*; #(
  parameter int PASS_TIMEOUT = PASS_TIMEOUT_DEF,
  parameter int CLOSE_CYCLES = CLOSE_CYCLES_DEF
) (
  input  logic clk,
  input  logic reset,
  input  logic approach,
  input  logic pass,
  input  logic allow,
  output logic gate_up,
  output logic idle,
  output logic fire,
  output logic timeout
);

  localparam int TIMER_W = $clog2(max_int(PASS_TIMEOUT, CLOSE_CYCLES) + 1);

  gate_state_t        state, state_nxt;
  logic [TIMER_W-1:0] timer, timer_nxt;

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      timer   <= '0;
      gate_up <= 1'b0;
    end else begin
      state   <= state_nxt;
      timer   <= timer_nxt;
      gate_up <= (state_nxt == OPEN) || (state_nxt == PASSED);
    end
  end

  // Every transition clears the timer, so it always counts cycles spent in
  // the current state.
  always_comb begin
    state_nxt = state;
    timer_nxt = timer;
    fire      = 1'b0;
    timeout   = 1'b0;
    case (state)
      IDLE: begin
        if (approach && allow) begin
          state_nxt = OPEN;
          timer_nxt = '0;
        end
      end
      OPEN: begin
        if (pass) begin
          state_nxt = PASSED;
          timer_nxt = '0;
          fire      = 1'b1;
        end else if (timer == TIMER_W'(PASS_TIMEOUT - 1)) begin
          state_nxt = CLOSE;
          timer_nxt = '0;
          timeout   = 1'b1;
        end else begin
          timer_nxt = timer + 1'b1;
        end
      end
      PASSED: begin
        if (!pass) begin
          state_nxt = CLOSE;
          timer_nxt = '0;
        end
      end
      CLOSE: begin
        if (timer == TIMER_W'(CLOSE_CYCLES - 1)) begin
          state_nxt = IDLE;
          timer_nxt = '0;
        end else begin
          timer_nxt = timer + 1'b1;
        end
      end
      default: begin
        state_nxt = IDLE;
        timer_nxt = '0;
      end
    endcase
  end

  assign idle = (state == IDLE);

endmodule

// File: rtl/parking_gate_ctrl.sv
// Barrier controller for one car park's entry and exit lanes.
// Raises the barriers, emits one-cycle entry/exit events for the occupancy
// counter (never both in the same cycle) and flags refused entries.
// Ports:
//   clk, reset                   system clock, synchronous active-high reset
//   entry_approach, entry_pass   debounced entry lane sensors
//   exit_approach,  exit_pass    debounced exit lane sensors
//   space_avail                  counter reports at least one free space
//   entry_gate_up, exit_gate_up  barrier drives, 1 = raised
//   entry_pulse, exit_pulse      one-cycle "car entered" / "car left" events
//   entry_denied                 entry idle with a car waiting and no space
// Build option GATE_STATS_EN adds saturating 16-bit counters:
//   denied_count   rising edges of entry_denied
//   timeout_count  pass-sensor timeouts on either lane
module parking_gate_ctrl import parking_pkg::*; #(
  parameter int PASS_TIMEOUT = PASS_TIMEOUT_DEF,
  parameter int CLOSE_CYCLES = CLOSE_CYCLES_DEF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        entry_approach,
  input  logic        entry_pass,
  input  logic        exit_approach,
  input  logic        exit_pass,
  input  logic        space_avail,
  output logic        entry_gate_up,
  output logic        exit_gate_up,
  output logic        entry_pulse,
  output logic        exit_pulse,
  output logic        entry_denied
`ifdef GATE_STATS_EN
  ,
  output logic [15:0] denied_count,
  output logic [15:0] timeout_count
`endif
);

  logic entry_idle, exit_idle;
  logic entry_fire, exit_fire;
  logic entry_timeout, exit_timeout;
  logic exit_pending;
  logic denied_now;

  gate_lane_fsm #(
    .PASS_TIMEOUT (PASS_TIMEOUT),
    .CLOSE_CYCLES (CLOSE_CYCLES)
  ) u_entry_lane (
    .clk      (clk),
    .reset    (reset),
    .approach (entry_approach),
    .pass     (entry_pass),
    .allow    (space_avail),
    .gate_up  (entry_gate_up),
    .idle     (entry_idle),
    .fire     (entry_fire),
    .timeout  (entry_timeout)
  );

  gate_lane_fsm #(
    .PASS_TIMEOUT (PASS_TIMEOUT),
    .CLOSE_CYCLES (CLOSE_CYCLES)
  ) u_exit_lane (
    .clk      (clk),
    .reset    (reset),
    .approach (exit_approach),
    .pass     (exit_pass),
    .allow    (1'b1),
    .gate_up  (exit_gate_up),
    .idle     (exit_idle),
    .fire     (exit_fire),
    .timeout  (exit_timeout)
  );

  assign denied_now = entry_idle & entry_approach & ~space_avail;

  // Entry wins a simultaneous event; the exit event waits one cycle in
  // exit_pending. Both lanes sit in PASSED while the deferred pulse goes
  // out, so neither can fire again in that cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      entry_pulse  <= 1'b0;
      exit_pulse   <= 1'b0;
      exit_pending <= 1'b0;
      entry_denied <= 1'b0;
    end else begin
      entry_pulse  <= entry_fire;
      exit_pulse   <= exit_pending | (exit_fire & ~entry_fire);
      exit_pending <= exit_fire & entry_fire;
      entry_denied <= denied_now;
    end
  end

`ifdef GATE_STATS_EN
  logic [16:0] timeout_sum;

  // Both lanes may time out in the same cycle, hence the 17-bit sum.
  always_comb begin
    timeout_sum = {1'b0, timeout_count} + {16'd0, entry_timeout} + {16'd0, exit_timeout};
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      denied_count  <= 16'd0;
      timeout_count <= 16'd0;
    end else begin
      if (denied_now && !entry_denied && (denied_count != 16'hFFFF)) begin
        denied_count <= denied_count + 16'd1;
      end
      timeout_count <= timeout_sum[16] ? 16'hFFFF : timeout_sum[15:0];
    end
  end

  // The exit lane is never refused, so its idle flag has no consumer.
  logic unused_ok;
  assign unused_ok = exit_idle;
`else
  logic unused_ok;
  assign unused_ok = exit_idle | entry_timeout | exit_timeout;
`endif

endmodule

// File: tb/tb_parking_gate_ctrl.sv
// Self-checking bench for parking_gate_ctrl with PASS_TIMEOUT=8, CLOSE_CYCLES=4.
// Directed scenarios plus a randomized run against a lane model that tracks
// "barrier raised", "car through", "time up" and "hold remaining".
module tb_parking_gate_ctrl;

  localparam int PT = 8;
  localparam int CC = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic ea = 1'b0, ep = 1'b0, xa = 1'b0, xp = 1'b0, sa = 1'b0;
  logic entry_gate_up, exit_gate_up, entry_pulse, exit_pulse, entry_denied;
`ifdef GATE_STATS_EN
  logic [15:0] denied_count, timeout_count;
`endif

  int checks = 0;
  int failures = 0;

  parking_gate_ctrl #(.PASS_TIMEOUT(PT), .CLOSE_CYCLES(CC)) dut (
    .clk            (clk),
    .reset          (rst),
    .entry_approach (ea),
    .entry_pass     (ep),
    .exit_approach  (xa),
    .exit_pass      (xp),
    .space_avail    (sa),
    .entry_gate_up  (entry_gate_up),
    .exit_gate_up   (exit_gate_up),
    .entry_pulse    (entry_pulse),
    .exit_pulse     (exit_pulse),
    .entry_denied   (entry_denied)
`ifdef GATE_STATS_EN
    ,
    .denied_count   (denied_count),
    .timeout_count  (timeout_count)
`endif
  );

  always #5 clk = ~clk;

  // Reference model (index 0 = entry, 1 = exit)
  bit m_up[2];
  int m_age[2];
  bit m_thru[2];
  int m_hold[2];
  bit x_epulse, x_xpulse, x_pend, x_denied;
  int x_dcnt, x_tcnt;

  task automatic model_update();
    bit appr[2], pas[2], alw[2], ev[2], tmo[2];
    bit den;
    if (rst) begin
      for (int i = 0; i < 2; i++) begin
        m_up[i] = 0; m_age[i] = 0; m_thru[i] = 0; m_hold[i] = 0;
      end
      x_epulse = 0; x_xpulse = 0; x_pend = 0; x_denied = 0;
      x_dcnt = 0; x_tcnt = 0;
      return;
    end
    appr = '{ea, xa};
    pas  = '{ep, xp};
    alw  = '{sa, 1'b1};
    den  = !m_up[0] && (m_hold[0] == 0) && ea && !sa;
    for (int i = 0; i < 2; i++) begin
      ev[i] = 0; tmo[i] = 0;
      if (m_up[i] && !m_thru[i]) begin
        if (pas[i]) begin m_thru[i] = 1; ev[i] = 1; end
        else if (m_age[i] == PT - 1) begin m_up[i] = 0; m_hold[i] = CC; tmo[i] = 1; end
        else m_age[i]++;
      end else if (m_up[i]) begin
        if (!pas[i]) begin m_up[i] = 0; m_hold[i] = CC; end
      end else if (m_hold[i] > 0) begin
        m_hold[i]--;
      end else if (appr[i] && alw[i]) begin
        m_up[i] = 1; m_age[i] = 0; m_thru[i] = 0;
      end
    end
    x_xpulse = x_pend || (ev[1] && !ev[0]);
    x_pend   = ev[0] && ev[1];
    x_epulse = ev[0];
    if (den && !x_denied && x_dcnt < 65535) x_dcnt++;
    x_denied = den;
    x_tcnt = x_tcnt + int'(tmo[0]) + int'(tmo[1]);
    if (x_tcnt > 65535) x_tcnt = 65535;
  endtask

  task automatic step();
    @(posedge clk);
    model_update();
    @(negedge clk);
  endtask

  function automatic logic [4:0] dut_vec();
    return {entry_gate_up, exit_gate_up, entry_pulse, exit_pulse, entry_denied};
  endfunction

  function automatic logic [4:0] mdl_vec();
    return {m_up[0], m_up[1], x_epulse, x_xpulse, x_denied};
  endfunction

  task automatic start_clean();
    ea = 0; ep = 0; xa = 0; xp = 0; sa = 0;
    rst = 1; step(); rst = 0;
  endtask

  task automatic test_reset();
    rst = 1; step(); step();
    checks++;
    if (dut_vec() !== 5'b00000) begin
      failures++; $display("FAIL reset_outputs got=%b exp=00000", dut_vec());
    end
`ifdef GATE_STATS_EN
    checks++;
    if ({denied_count, timeout_count} !== 32'd0) begin
      failures++; $display("FAIL reset_stats got=%0h/%0h exp=0/0", denied_count, timeout_count);
    end
`endif
    rst = 0;
  endtask

  task automatic test_normal_entry();
    int pulses = 0;
    int low = 1;
    start_clean();
    sa = 1; ea = 1; step();
    checks++;
    if (entry_gate_up !== 1'b1) begin
      failures++; $display("FAIL entry_open got=%b exp=1", entry_gate_up);
    end
    ea = 0;
    for (int k = 0; k < 2; k++) begin step(); pulses += int'(entry_pulse); end
    ep = 1; step(); pulses += int'(entry_pulse);
    checks++;
    if (entry_pulse !== 1'b1) begin
      failures++; $display("FAIL entry_pulse_latency got=%b exp=1", entry_pulse);
    end
    step(); pulses += int'(entry_pulse);
    ep = 0; step(); pulses += int'(entry_pulse);
    checks++;
    if (entry_gate_up !== 1'b0) begin
      failures++; $display("FAIL entry_close got=%b exp=0", entry_gate_up);
    end
    // Gate stays low for the hold cycles plus the IDLE cycle that samples approach.
    ea = 1;
    for (int k = 0; k < 20 && entry_gate_up === 1'b0; k++) begin
      step(); pulses += int'(entry_pulse);
      if (entry_gate_up === 1'b0) low++;
      checks++;
      if (dut_vec() !== mdl_vec()) begin
        failures++; $display("FAIL entry_rearm_model got=%b exp=%b", dut_vec(), mdl_vec());
      end
    end
    checks++;
    if (low !== CC + 1) begin
      failures++; $display("FAIL entry_rearm_len got=%0d exp=%0d", low, CC + 1);
    end
    checks++;
    if (pulses !== 1) begin
      failures++; $display("FAIL entry_pulse_count got=%0d exp=1", pulses);
    end
  endtask

  task automatic test_park_full();
    start_clean();
    sa = 0; ea = 1;
    for (int k = 0; k < 20; k++) begin
      step();
      checks++;
      if ({entry_gate_up, entry_denied, entry_pulse} !== 3'b010) begin
        failures++;
        $display("FAIL park_full cyc=%0d got=%b exp=010", k, {entry_gate_up, entry_denied, entry_pulse});
      end
    end
`ifdef GATE_STATS_EN
    checks++;
    if (denied_count !== 16'd1) begin
      failures++; $display("FAIL denied_count got=%0d exp=1", denied_count);
    end
`endif
  endtask

  task automatic test_timeout();
    int up = 0;
    int pulses = 0;
    start_clean();
    sa = 1; ea = 1; step(); up += int'(entry_gate_up);
    ea = 0;
    for (int k = 0; k < 20; k++) begin
      step(); up += int'(entry_gate_up); pulses += int'(entry_pulse);
    end
    checks++;
    if (up !== PT) begin
      failures++; $display("FAIL timeout_up_cycles got=%0d exp=%0d", up, PT);
    end
    checks++;
    if (pulses !== 0) begin
      failures++; $display("FAIL timeout_no_pulse got=%0d exp=0", pulses);
    end
`ifdef GATE_STATS_EN
    checks++;
    if (timeout_count !== 16'd1) begin
      failures++; $display("FAIL timeout_count got=%0d exp=1", timeout_count);
    end
`endif
  endtask

  task automatic test_collision();
    start_clean();
    sa = 1; ea = 1; xa = 1; step();
    ea = 0; xa = 0; step();
    ep = 1; xp = 1; step();
    checks++;
    if ({entry_pulse, exit_pulse} !== 2'b10) begin
      failures++; $display("FAIL collision_t1 got=%b exp=10", {entry_pulse, exit_pulse});
    end
    ep = 0; xp = 0; step();
    checks++;
    if ({entry_pulse, exit_pulse} !== 2'b01) begin
      failures++; $display("FAIL collision_t2 got=%b exp=01", {entry_pulse, exit_pulse});
    end
    step();
    checks++;
    if ({entry_pulse, exit_pulse} !== 2'b00) begin
      failures++; $display("FAIL collision_t3 got=%b exp=00", {entry_pulse, exit_pulse});
    end
  endtask

  task automatic test_reset_mid();
    start_clean();
    sa = 1; ea = 1; step();
    ea = 0; ep = 1; step(); step();
    rst = 1; step();
    checks++;
    if (dut_vec() !== 5'b00000) begin
      failures++; $display("FAIL reset_in_passed got=%b exp=00000", dut_vec());
    end
    rst = 0; ep = 0;
    for (int k = 0; k < 6; k++) begin
      step();
      checks++;
      if ({entry_gate_up, entry_pulse, exit_pulse} !== 3'b000) begin
        failures++; $display("FAIL reset_after got=%b exp=000", {entry_gate_up, entry_pulse, exit_pulse});
      end
    end
    ea = 1; step();
    checks++;
    if (entry_gate_up !== 1'b1) begin
      failures++; $display("FAIL reset_lane_idle got=%b exp=1", entry_gate_up);
    end
    // Reset in the very cycle the car passes: the event must be dropped.
    ea = 0; ep = 1; rst = 1; step();
    rst = 0; ep = 0; step();
    checks++;
    if ({entry_gate_up, entry_pulse} !== 2'b00) begin
      failures++; $display("FAIL reset_abort_event got=%b exp=00", {entry_gate_up, entry_pulse});
    end
  endtask

  task automatic test_avail_drop();
    start_clean();
    sa = 1; ea = 1; step();
    sa = 0; ea = 0; step(); step();
    checks++;
    if ({entry_gate_up, entry_denied} !== 2'b10) begin
      failures++; $display("FAIL avail_drop_gate got=%b exp=10", {entry_gate_up, entry_denied});
    end
    ep = 1; step();
    checks++;
    if ({entry_gate_up, entry_pulse} !== 2'b11) begin
      failures++; $display("FAIL avail_drop_pulse got=%b exp=11", {entry_gate_up, entry_pulse});
    end
    ep = 0;
  endtask

  task automatic test_random();
    start_clean();
    for (int k = 0; k < 3000; k++) begin
      rst = ($urandom_range(0, 199) == 0);
      ea  = ($urandom_range(0, 99) < 30);
      xa  = ($urandom_range(0, 99) < 30);
      ep  = ($urandom_range(0, 99) < 35);
      xp  = ($urandom_range(0, 99) < 35);
      sa  = ($urandom_range(0, 99) < 65);
      step();
      checks++;
      if (dut_vec() !== mdl_vec()) begin
        failures++; $display("FAIL random_model cyc=%0d got=%b exp=%b", k, dut_vec(), mdl_vec());
      end
      checks++;
      if (entry_pulse === 1'b1 && exit_pulse === 1'b1) begin
        failures++; $display("FAIL random_overlap cyc=%0d got=11 exp=not both", k);
      end
`ifdef GATE_STATS_EN
      checks++;
      if (denied_count !== x_dcnt[15:0] || timeout_count !== x_tcnt[15:0]) begin
        failures++;
        $display("FAIL random_stats cyc=%0d got=%0d/%0d exp=%0d/%0d", k, denied_count, timeout_count, x_dcnt, x_tcnt);
      end
`endif
    end
    rst = 0;
  endtask

  initial begin
    @(negedge clk);
    test_reset();
    test_normal_entry();
    test_park_full();
    test_timeout();
    test_collision();
    test_reset_mid();
    test_avail_drop();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
